// File: rtl/bus_pkg.sv
// Shared bus types and default widths for the memory-bus fabric.
// The CPU top and the arbiter both import this package.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  // Width of a master index; a single master still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/response bundle plus the single slave-side bus.
// The arbiter connects through "master" (it masters the slave bus); the environment uses "slave".
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W
);

  logic [NUM_MASTERS-1:0]             m_read;
  logic [NUM_MASTERS-1:0]             m_write;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0]                  m_rdata;
  logic [NUM_MASTERS-1:0]             m_ready;
  logic [NUM_MASTERS-1:0]             m_error;

  logic                               s_read;
  logic                               s_write;
  logic [ADDR_W-1:0]                  s_addr;
  logic [DATA_W-1:0]                  s_wdata;
  logic [DATA_W-1:0]                  s_rdata;
  logic                               s_ready;

  modport master (
    input  m_read, m_write, m_addr, m_wdata, s_rdata, s_ready,
    output m_rdata, m_ready, m_error, s_read, s_write, s_addr, s_wdata
  );

  modport slave (
    output m_read, m_write, m_addr, m_wdata, s_rdata, s_ready,
    input  m_rdata, m_ready, m_error, s_read, s_write, s_addr, s_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 upward, wrapping.
// grant is only meaningful while any_req is high.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int GW          = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GW-1:0]          last_grant,
  output logic [GW-1:0]          grant,
  output logic                   any_req
);

  int   idx;
  logic found;

  always_comb begin
    grant = last_grant;
    found = 1'b0;
    idx   = 0;
    // Offset 1..N visits every master once, last_grant itself last.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last_grant) + i) % NUM_MASTERS;
      if (!found && req[idx[GW-1:0]]) begin
        grant = idx[GW-1:0];
        found = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// N-master, single-slave bus arbiter with round-robin grant, s_ready handshake
// and a per-transaction timeout that returns m_error to the stalled master.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int TIMEOUT     = 16
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  localparam int             GW        = idx_w(NUM_MASTERS);
  localparam int             CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GRANT_RST = GW'(NUM_MASTERS - 1);

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                s_read_q, s_read_d;
  logic                s_write_q, s_write_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;

  logic [NUM_MASTERS-1:0] req;
  logic [GW-1:0]          arb_grant;
  logic                   any_req;
  op_e                    op_sel;
  logic                   busy;
  logic                   timeout_hit;
  logic                   done;

  assign req = bus.m_read | bus.m_write;

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  assign busy        = (state_q == BUSY);
  // s_ready on the final count wins over the timeout.
  assign timeout_hit = busy && !bus.s_ready && (cnt_q == CNT_LAST);
  assign done        = busy && (bus.s_ready || timeout_hit);
  // Read and write together from one master is treated as a write.
  assign op_sel      = bus.m_write[arb_grant] ? OP_WRITE : OP_READ;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    s_read_d     = s_read_q;
    s_write_d    = s_write_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = BUSY;
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          cnt_d        = '0;
          s_read_d     = (op_sel == OP_READ);
          s_write_d    = (op_sel == OP_WRITE);
          s_addr_d     = bus.m_addr[arb_grant];
          s_wdata_d    = bus.m_wdata[arb_grant];
        end
      end
      BUSY: begin
        if (done) begin
          state_d   = IDLE;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          s_addr_d  = '0;
          s_wdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_RST;
      cnt_q        <= '0;
      s_read_q     <= 1'b0;
      s_write_q    <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      s_read_q     <= s_read_d;
      s_write_q    <= s_write_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
    end
  end

  assign bus.s_read  = s_read_q;
  assign bus.s_write = s_write_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.m_rdata = busy ? bus.s_rdata : '0;

  // Completion and error responses are combinational so a zero-wait slave finishes in 2 cycles.
  always_comb begin
    bus.m_ready = '0;
    bus.m_error = '0;
    if (busy && bus.s_ready) bus.m_ready[grant_q] = 1'b1;
    if (timeout_hit)         bus.m_error[grant_q] = 1'b1;
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(bus.m_ready));
  a_ready_xor_error: assert property (@(posedge clk) disable iff (!rst)
    !((|bus.m_ready) && (|bus.m_error)));
  a_single_strobe: assert property (@(posedge clk) disable iff (!rst)
    !(bus.s_read && bus.s_write));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: two masters, TIMEOUT=16, simple delay-programmable slave.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus ();

  bus_arbiter #(
    .NUM_MASTERS(2),
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Slave answers on strobe cycle slave_delay+1; a negative delay never answers.
  int slave_delay = 0;
  int slv_cnt     = 0;
  always @(posedge clk)
    slv_cnt <= ((bus.s_read || bus.s_write) && !bus.s_ready) ? slv_cnt + 1 : 0;
  assign bus.s_ready = (bus.s_read || bus.s_write) && (slave_delay >= 0) && (slv_cnt == slave_delay);

  task automatic clear_inputs;
    bus.m_read  = '0;
    bus.m_write = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_rdata = '0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.s_read, bus.s_write, bus.m_ready, bus.m_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp %b", {bus.s_read, bus.s_write, bus.m_ready, bus.m_error}, 6'b0);
    end
    checks++;
    if (bus.s_addr !== 32'h0 || bus.s_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got addr %h wdata %h exp 0", bus.s_addr, bus.s_wdata);
    end
    checks++;
    if (bus.m_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 0", bus.m_rdata);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_read;
    bus.s_rdata    = 32'hDEADBEEF;
    slave_delay    = 0;
    bus.m_addr[0]  = 32'h100;
    bus.m_read[0]  = 1'b1;
    #1;
    checks++;
    if (bus.s_read !== 1'b0) begin
      errors++;
      $display("FAIL read_early_strobe got %b exp 0", bus.s_read);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.s_read, bus.s_write} !== 2'b10 || bus.s_addr !== 32'h100) begin
      errors++;
      $display("FAIL read_strobe got rw %b addr %h exp rw 10 addr 00000100", {bus.s_read, bus.s_write}, bus.s_addr);
    end
    checks++;
    if (bus.m_ready !== 2'b01 || bus.m_error !== 2'b00) begin
      errors++;
      $display("FAIL read_ready got rdy %b err %b exp rdy 01 err 00", bus.m_ready, bus.m_error);
    end
    checks++;
    if (bus.m_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_rdata got %h exp deadbeef", bus.m_rdata);
    end
    bus.m_read[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.s_read !== 1'b0 || bus.m_ready !== 2'b00 || bus.m_rdata !== 32'h0) begin
      errors++;
      $display("FAIL read_idle got strobe %b rdy %b rdata %h exp 0 00 0", bus.s_read, bus.m_ready, bus.m_rdata);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp_rdy  [8];
    logic [31:0] exp_addr [8];
    do_reset();
    exp_rdy  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    exp_addr = '{32'h10, 32'h0, 32'h20, 32'h0, 32'h10, 32'h0, 32'h20, 32'h0};
    slave_delay   = 0;
    bus.s_rdata   = 32'hA5A5A5A5;
    bus.m_addr[0] = 32'h10;
    bus.m_addr[1] = 32'h20;
    bus.m_read    = 2'b11;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.m_ready !== exp_rdy[c] || bus.m_error !== 2'b00) begin
        errors++;
        $display("FAIL rr_ready[%0d] got rdy %b err %b exp rdy %b err 00", c, bus.m_ready, bus.m_error, exp_rdy[c]);
      end
      checks++;
      if (bus.s_addr !== exp_addr[c]) begin
        errors++;
        $display("FAIL rr_addr[%0d] got %h exp %h", c, bus.s_addr, exp_addr[c]);
      end
      if (c == 7) bus.m_read = 2'b00;
    end
    @(posedge clk); #1;
    checks++;
    if (bus.s_read !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain got strobe %b exp 0", bus.s_read);
    end
  endtask

  task automatic test_wait_write;
    slave_delay    = 5;
    bus.m_addr[1]  = 32'h200;
    bus.m_wdata[1] = 32'h55AA;
    bus.m_write[1] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.s_read, bus.s_write} !== 2'b01 || bus.s_addr !== 32'h200 || bus.s_wdata !== 32'h55AA) begin
        errors++;
        $display("FAIL wr_hold[%0d] got rw %b addr %h wdata %h exp 01 200 55aa", c, {bus.s_read, bus.s_write}, bus.s_addr, bus.s_wdata);
      end
      checks++;
      if (bus.m_ready !== ((c == 6) ? 2'b10 : 2'b00) || bus.m_error !== 2'b00) begin
        errors++;
        $display("FAIL wr_resp[%0d] got rdy %b err %b exp rdy %b err 00", c, bus.m_ready, bus.m_error, (c == 6) ? 2'b10 : 2'b00);
      end
    end
    bus.m_write[1] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.s_write !== 1'b0) begin
      errors++;
      $display("FAIL wr_release got %b exp 0", bus.s_write);
    end
  endtask

  task automatic test_timeout;
    slave_delay   = -1;
    bus.m_addr[0] = 32'h300;
    bus.m_read[0] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.s_read !== 1'b1 || bus.m_ready !== 2'b00 || bus.m_error !== ((c == 16) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL to_err[%0d] got strobe %b rdy %b err %b exp 1 00 %b", c, bus.s_read, bus.m_ready, bus.m_error, (c == 16) ? 2'b01 : 2'b00);
      end
    end
    bus.m_read[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.s_read !== 1'b0 || bus.m_error !== 2'b00) begin
      errors++;
      $display("FAIL to_idle got strobe %b err %b exp 0 00", bus.s_read, bus.m_error);
    end
    slave_delay   = 15;
    bus.m_read[0] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.m_ready !== ((c == 16) ? 2'b01 : 2'b00) || bus.m_error !== 2'b00) begin
        errors++;
        $display("FAIL to_edge[%0d] got rdy %b err %b exp rdy %b err 00", c, bus.m_ready, bus.m_error, (c == 16) ? 2'b01 : 2'b00);
      end
    end
    bus.m_read[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    slave_delay    = -1;
    bus.m_addr[0]  = 32'h400;
    bus.m_wdata[0] = 32'h77;
    bus.m_write[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.s_write !== 1'b1 || bus.s_addr !== 32'h400) begin
      errors++;
      $display("FAIL mid_busy got strobe %b addr %h exp 1 400", bus.s_write, bus.s_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.s_read, bus.s_write, bus.m_ready, bus.m_error} !== 6'b0 || bus.s_addr !== 32'h0 ||
        bus.s_wdata !== 32'h0 || bus.m_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got ctl %b addr %h wdata %h rdata %h exp all 0",
               {bus.s_read, bus.s_write, bus.m_ready, bus.m_error}, bus.s_addr, bus.s_wdata, bus.m_rdata);
    end
    rst            = 1'b1;
    slave_delay    = 0;
    bus.m_write[0] = 1'b0;
    bus.m_addr[0]  = 32'h10;
    bus.m_addr[1]  = 32'h20;
    bus.m_read     = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (bus.m_ready !== 2'b01 || bus.s_addr !== 32'h10) begin
      errors++;
      $display("FAIL mid_first_grant got rdy %b addr %h exp 01 10", bus.m_ready, bus.s_addr);
    end
    bus.m_read = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_read_write_both;
    slave_delay    = 0;
    bus.m_addr[0]  = 32'h500;
    bus.m_wdata[0] = 32'h1234;
    bus.m_read[0]  = 1'b1;
    bus.m_write[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.s_read, bus.s_write} !== 2'b01 || bus.s_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL rw_both got rw %b wdata %h exp 01 1234", {bus.s_read, bus.s_write}, bus.s_wdata);
    end
    checks++;
    if (bus.m_ready !== 2'b01) begin
      errors++;
      $display("FAIL rw_both_ready got %b exp 01", bus.m_ready);
    end
    bus.m_read[0]  = 1'b0;
    bus.m_write[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_write();
    test_timeout();
    test_reset_mid();
    test_read_write_both();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
